// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-refill / write-back memory arbiter.
package mem_arbiter_pkg;
  localparam int ARB_LINE_WORDS = 4;

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, DONE} arb_state_t;
  typedef enum logic {ARB_OWNER_I, ARB_OWNER_D} arb_owner_t;

  // Line-aligned burst base: drop the word-in-line and byte-in-word bits.
  function automatic logic [31:0] line_base(input logic [31:0] a, input int bw);
    line_base = a & ~((32'd1 << (bw + 2)) - 32'd1);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int LINE_WORDS = ARB_LINE_WORDS
);
  localparam int BW = $clog2(LINE_WORDS);

  logic          ireq_i;
  logic [31:0]   iaddr_i;
  logic          igrant_o;
  logic          irvalid_o;
  logic [31:0]   irdata_o;
  logic          idone_o;

  logic          dreq_i;
  logic          dwe_i;
  logic [31:0]   daddr_i;
  logic [31:0]   dwdata_i;
  logic          dgrant_o;
  logic          drvalid_o;
  logic [31:0]   drdata_o;
  logic          ddone_o;

  logic [BW-1:0] beat_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic          mem_ready_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_wvalid_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_wready_i;

  logic          busy_o;

  modport slave (
    input  ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_wready_i,
    output igrant_o, irvalid_o, irdata_o, idone_o,
           dgrant_o, drvalid_o, drdata_o, ddone_o, beat_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wvalid_o, mem_wdata_o, busy_o
  );

  modport master (
    output ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_wready_i,
    input  igrant_o, irvalid_o, irdata_o, idone_o,
           dgrant_o, drvalid_o, drdata_o, ddone_o, beat_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wvalid_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (I$ refill, D$ refill/write-back) line-burst arbiter onto one memory port.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int LINE_WORDS = ARB_LINE_WORDS,
  parameter int DEBUG      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);
  localparam int            BW   = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

  arb_state_t    state;
  arb_owner_t    owner;
  arb_owner_t    last;
  logic [31:0]   addr;
  logic          we;
  logic [BW-1:0] beat;

  logic d_wins, own_d, own_i, in_rd, in_wr;

  // Alternate under contention: data wins unless it owned the last completed burst.
  assign d_wins = bus.dreq_i && (!bus.ireq_i || last == ARB_OWNER_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= ARB_OWNER_I;
      last  <= ARB_OWNER_I;
      addr  <= '0;
      we    <= 1'b0;
      beat  <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.ireq_i || bus.dreq_i) begin
          owner <= d_wins ? ARB_OWNER_D : ARB_OWNER_I;
          addr  <= d_wins ? bus.daddr_i : bus.iaddr_i;
          we    <= d_wins && bus.dwe_i;
          state <= ADDR;
        end
        ADDR: if (bus.mem_ready_i) state <= we ? WDATA : RDATA;
        RDATA: if (bus.mem_rvalid_i) begin
          beat <= beat + BW'(1);
          if (beat == LAST) state <= DONE;
        end
        WDATA: if (bus.mem_wready_i) begin
          beat <= beat + BW'(1);
          if (beat == LAST) state <= DONE;
        end
        DONE: begin
          last  <= owner;
          beat  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output decodes from state, so async reset forces them all low at once.
  assign own_d = (owner == ARB_OWNER_D);
  assign own_i = !own_d;
  assign in_rd = (state == RDATA);
  assign in_wr = (state == WDATA);

  assign bus.busy_o       = (state != IDLE);
  assign bus.igrant_o     = bus.busy_o && own_i;
  assign bus.dgrant_o     = bus.busy_o && own_d;

  assign bus.mem_req_o    = (state == ADDR);
  assign bus.mem_we_o     = bus.mem_req_o && we;
  assign bus.mem_addr_o   = bus.mem_req_o ? line_base(addr, BW) : '0;

  assign bus.irvalid_o    = in_rd && own_i && bus.mem_rvalid_i;
  assign bus.drvalid_o    = in_rd && own_d && bus.mem_rvalid_i;
  assign bus.irdata_o     = bus.irvalid_o ? bus.mem_rdata_i : '0;
  assign bus.drdata_o     = bus.drvalid_o ? bus.mem_rdata_i : '0;

  assign bus.mem_wvalid_o = in_wr;
  assign bus.mem_wdata_o  = in_wr ? bus.dwdata_i : '0;

  assign bus.idone_o      = (state == DONE) && own_i;
  assign bus.ddone_o      = (state == DONE) && own_d;
  assign bus.beat_o       = beat;

  generate
    if (DEBUG != 0) begin : g_dbg
      always @(posedge clk) begin
        if (rst_n) begin
          assert (!(bus.igrant_o && bus.dgrant_o));
          assert (state != IDLE || beat == '0);
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter plus a LINE_WORDS=8 directed burst.
module tb_mem_arbiter;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_WORDS(LW)) bus();
  mem_arbiter_if #(.LINE_WORDS(8))  b8();

  mem_arbiter #(.LINE_WORDS(LW), .DEBUG(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_arbiter #(.LINE_WORDS(8),  .DEBUG(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    bit          d;
    logic [31:0] addr;
    bit          we;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_d = 1'b0;

  function automatic logic [31:0] rd_fn(logic [31:0] a, int b);
    return ((a + 32'(b) * 32'h0101_0101) * 32'h9E37_79B1) ^ 32'(b);
  endfunction

  function automatic logic [31:0] wd_fn(logic [31:0] a, int b);
    return (a * 32'h85EB_CA6B) ^ 32'hA5A5_0000 ^ (32'(b) << 4);
  endfunction

  function automatic logic [31:0] base(logic [31:0] a, int lw);
    return a & ~(32'(lw) * 32'd4 - 32'd1);
  endfunction

  function automatic bit outs_nz();
    return |{bus.igrant_o, bus.irvalid_o, bus.irdata_o, bus.idone_o,
             bus.dgrant_o, bus.drvalid_o, bus.drdata_o, bus.ddone_o, bus.beat_o,
             bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
             bus.mem_wvalid_o, bus.mem_wdata_o, bus.busy_o};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit d, logic [31:0] a, bit w);
    txn_t t;
    t.d = d; t.addr = a; t.we = w;
    exp_q.push_back(t);
  endtask

  // Data cache model: write beat data is a function of line address and beat index.
  assign bus.dwdata_i = wd_fn(bus.daddr_i, 32'(bus.beat_o));

  // Memory responder: randomized handshakes, spurious strobes outside bursts.
  bit          acc_n, acc_we, rbeat_n, rd_phase;
  logic [31:0] acc_addr, ra;
  int          rc;

  always @(negedge clk) begin
    acc_n    = rst_n && bus.mem_req_o && bus.mem_ready_i;
    acc_we   = bus.mem_we_o;
    acc_addr = bus.mem_addr_o;
    rbeat_n  = rst_n && rd_phase && bus.mem_rvalid_i;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rd_phase = 1'b0; rc = 0;
      bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_wready_i = 1'b0;
      bus.mem_rdata_i = '0;
    end else begin
      if (rbeat_n) begin
        rc++;
        if (rc == LW) rd_phase = 1'b0;
      end
      if (acc_n && !acc_we) begin
        rd_phase = 1'b1; rc = 0; ra = acc_addr;
      end
      bus.mem_ready_i  = ($urandom_range(0, 1) != 0);
      bus.mem_wready_i = ($urandom_range(0, 2) != 0);
      bus.mem_rvalid_i = ($urandom_range(0, 2) != 0);
      bus.mem_rdata_i  = rd_phase ? rd_fn(ra, rc) : $urandom;
    end
  end

  // Monitor: pops the expected burst at its address phase and checks each beat and the done.
  bit   active = 1'b0;
  txn_t cur;
  int   cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      chk("grant_excl", 32'(bus.igrant_o && bus.dgrant_o), 0);
      if (bus.mem_req_o) begin
        if (!active) begin
          chk("grant_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            active = 1'b1;
            cnt = 0;
            chk("owner_d", 32'(bus.dgrant_o), 32'(cur.d));
            chk("owner_i", 32'(bus.igrant_o), 32'(!cur.d));
          end
        end
        if (active) begin
          chk("mem_addr", bus.mem_addr_o, base(cur.addr, LW));
          chk("mem_we", 32'(bus.mem_we_o), 32'(cur.we));
        end
      end
      if (bus.irvalid_o || bus.drvalid_o) begin
        chk("rvalid_in_read", 32'(active && !cur.we && !bus.mem_req_o), 1);
        if (active) begin
          chk("rvalid_side", 32'({bus.drvalid_o, bus.irvalid_o}), cur.d ? 32'd2 : 32'd1);
          chk("rdata", bus.drvalid_o ? bus.drdata_o : bus.irdata_o, rd_fn(base(cur.addr, LW), cnt));
          chk("rbeat", 32'(bus.beat_o), 32'(cnt));
          cnt++;
        end
      end
      if (bus.mem_wvalid_o && bus.mem_wready_i) begin
        chk("wbeat_in_write", 32'(active && cur.we && !bus.mem_req_o), 1);
        if (active) begin
          chk("wdata", bus.mem_wdata_o, wd_fn(cur.addr, cnt));
          chk("wbeat", 32'(bus.beat_o), 32'(cnt));
          cnt++;
        end
      end
      if (bus.idone_o || bus.ddone_o) begin
        chk("done_active", 32'(active), 1);
        if (active) begin
          chk("done_side", 32'({bus.ddone_o, bus.idone_o}), cur.d ? 32'd2 : 32'd1);
          chk("done_beats", 32'(cnt), LW);
        end
        active = 1'b0;
      end
    end
  end

  // kind: 0 I only, 1 D only, 2 both, 3 I held through its own done (two bursts).
  task automatic run_item(int kind, logic [31:0] ia, logic [31:0] da, bit dw);
    int need_i, gi, gd;
    bit pi, pd, ok;
    case (kind)
      0: begin push(1'b0, ia, 1'b0); last_d = 1'b0; end
      1: begin push(1'b1, da, dw); last_d = 1'b1; end
      2: if (last_d) begin
           push(1'b0, ia, 1'b0); push(1'b1, da, dw); last_d = 1'b1;
         end else begin
           push(1'b1, da, dw); push(1'b0, ia, 1'b0); last_d = 1'b0;
         end
      default: begin push(1'b0, ia, 1'b0); push(1'b0, ia, 1'b0); last_d = 1'b0; end
    endcase
    need_i = (kind == 3) ? 2 : 1;
    bus.iaddr_i = ia;
    bus.daddr_i = da;
    bus.dwe_i   = (kind == 0 || kind == 3) ? ($urandom_range(0, 1) != 0) : dw;
    bus.ireq_i  = (kind != 1);
    bus.dreq_i  = (kind == 1 || kind == 2);
    gi = 0; gd = 0; pi = 1'b0; pd = 1'b0; ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk); #1;
      if (bus.igrant_o && !pi) gi++;
      if (bus.dgrant_o && !pd) gd++;
      pi = bus.igrant_o;
      pd = bus.dgrant_o;
      if (gi >= need_i) bus.ireq_i = 1'b0;
      if (gd >= 1) bus.dreq_i = 1'b0;
      if (!bus.ireq_i && !bus.dreq_i && !bus.busy_o) ok = 1'b1;
    end
    chk("item_complete", 32'(ok), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          n, beats;
    bit          seen_done;
    logic [31:0] got_addr;

    bus.ireq_i = 1'b0; bus.iaddr_i = '0; bus.dreq_i = 1'b0; bus.dwe_i = 1'b0; bus.daddr_i = '0;
    bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_wready_i = 1'b0;
    b8.ireq_i = 1'b0; b8.iaddr_i = '0; b8.dreq_i = 1'b0; b8.dwe_i = 1'b0; b8.daddr_i = '0;
    b8.dwdata_i = '0; b8.mem_ready_i = 1'b0; b8.mem_rvalid_i = 1'b0; b8.mem_rdata_i = '0;
    b8.mem_wready_i = 1'b0;

    #1;
    chk("reset_outputs", 32'(outs_nz()), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus.busy_o), 0);
    chk("idle_beat", 32'(bus.beat_o), 0);

    // Contention from reset, then the lone read, then a write-back.
    repeat (3) run_item(2, $urandom, $urandom, ($urandom_range(0, 1) != 0));
    run_item(0, 32'h0000_1234, $urandom, 1'b0);
    run_item(1, $urandom, 32'h0000_0080, 1'b1);
    run_item(3, $urandom, $urandom, 1'b0);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_item(int'($urandom_range(0, 3)), $urandom, $urandom, ($urandom_range(0, 1) != 0));
    end

    // Reset in the middle of a read burst.
    bus.iaddr_i = $urandom;
    bus.ireq_i  = 1'b1;
    push(1'b0, bus.iaddr_i, 1'b0);
    n = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (bus.irvalid_o) n++;
    end
    chk("midburst_beats", 32'(n), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.ireq_i = 1'b0;
    exp_q.delete();
    last_d = 1'b0;
    #1;
    chk("midburst_reset_outputs", 32'(outs_nz()), 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold_outputs", 32'(outs_nz()), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_item(2, $urandom, $urandom, 1'b0);
    run_item(0, $urandom, $urandom, 1'b0);

    // Eight-word line build.
    @(posedge clk); #1;
    b8.mem_ready_i = 1'b1; b8.mem_rvalid_i = 1'b1; b8.mem_rdata_i = 32'h55;
    b8.iaddr_i = 32'h0000_003F; b8.ireq_i = 1'b1;
    got_addr = '0; beats = 0; seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (b8.mem_req_o) got_addr = b8.mem_addr_o;
      if (b8.igrant_o) b8.ireq_i = 1'b0;
      if (b8.irvalid_o) beats++;
      if (b8.idone_o) seen_done = 1'b1;
    end
    chk("lw8_addr", got_addr, 32'h0000_0020);
    chk("lw8_beats", 32'(beats), 8);
    chk("lw8_done", 32'(seen_done), 1);
    @(negedge clk);
    chk("lw8_done_pulse", 32'(b8.idone_o), 0);

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache-line burst; power of two, range 2..16.
REQ-002 Parameter DEBUG, default 1, enables simulation-only assertions and has no effect on synthesised logic.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ireq_i  in  1; iaddr_i  in  32 -- instruction-cache refill request and miss address.
REQ-006 igrant_o  out  1; irvalid_o  out  1; irdata_o  out  32; idone_o  out  1 -- instruction-side grant, read beat strobe, read beat data, completion pulse.
REQ-007 dreq_i  in  1; dwe_i  in  1; daddr_i  in  32; dwdata_i  in  32 -- data-cache request, 1 = write-back, line address, write beat data.
REQ-008 dgrant_o  out  1; drvalid_o  out  1; drdata_o  out  32; ddone_o  out  1 -- data-side equivalents of REQ-006.
REQ-009 beat_o  out  log2(LINE_WORDS) -- current beat index; the granted cache supplies dwdata_i combinationally from it.
REQ-010 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_ready_i  in  1 -- memory address-phase handshake.
REQ-011 mem_rvalid_i  in  1; mem_rdata_i  in  32 -- memory read beats.
REQ-012 mem_wvalid_o  out  1; mem_wdata_o  out  32; mem_wready_i  in  1 -- memory write beats.
REQ-013 busy_o  out  1 -- high in every state except IDLE; consumed by the pipeline controller as a stall source.

Function
REQ-014 FSM states: IDLE, ADDR, RDATA, WDATA, DONE, held in one registered state variable.
REQ-015 IDLE: when ireq_i or dreq_i is high, latch the winner, its address, and its we; go to ADDR on the next cycle.
REQ-016 Arbitration when both requests are high: data wins unless the last completed grant was data, in which case instruction wins.
REQ-017 Arbitration, last-grant register: resets to "instruction", so data wins first contention; updated at DONE.
REQ-018 Instruction requests are always reads; dwe_i is sampled only when data wins.
REQ-019 ADDR: mem_req_o=1, mem_we_o=latched we, mem_addr_o=latched address with bits [log2(LINE_WORDS)+1:0] forced to 0.
REQ-020 ADDR: all three outputs held stable until a cycle with mem_ready_i=1, then go to RDATA (read) or WDATA (write).
REQ-021 RDATA: each cycle with mem_rvalid_i=1 forwards mem_rdata_i combinationally to the granted side's rdata and pulses its rvalid, then increments beat_o.
REQ-022 RDATA: the beat with beat_o=LINE_WORDS-1 transitions to DONE.
REQ-023 WDATA: mem_wvalid_o=1, mem_wdata_o=dwdata_i; beat_o increments on each cycle with mem_wready_i=1; the last accepted beat transitions to DONE.
REQ-024 DONE: lasts exactly one cycle; pulses the granted side's done, clears beat_o, updates last-grant (REQ-017), returns to IDLE.
REQ-025 Minimum request-to-request spacing: a new grant can occur on the cycle after DONE; there is no back-to-back grant inside DONE.
REQ-026 igrant_o/dgrant_o: high from ADDR through DONE inclusive for the owner only; never both high.
REQ-027 Request deassertion after grant is ignored: the burst always completes.
REQ-028 A request held high through its own DONE is treated as a new request in IDLE.
REQ-029 Strobes outside the active phase are ignored: mem_rvalid_i outside RDATA, and mem_wready_i outside WDATA.
REQ-030 The non-granted side's rvalid and done stay 0 at all times.

Reset
REQ-031 On rst_n=0, immediately and regardless of state: state=IDLE, beat_o=0, last-grant=instruction, latched address/we=0.
REQ-032 On rst_n=0, all outputs are 0, including mem_req_o, mem_wvalid_o, grants, strobes and busy_o.
REQ-033 Reset asserted mid-burst abandons the transaction; no done pulse is produced.

Structure
REQ-034 core_pkg gains an arb_state_t enum (the five states) and an ARB_LINE_WORDS default constant.
REQ-035 core_pkg gains typedef arb_owner_t (ARB_OWNER_I, ARB_OWNER_D).
REQ-036 Single module, no sub-modules; the next-state logic and the datapath mux are flat in mem_arbiter.
REQ-037 Instantiated in RV32Core between the cache refill ports and main memory when USE_CACHE=1.
REQ-038 busy_o is ORed into the controller's miss input.

Verification
REQ-039 Lone instruction read: ireq_i=1, iaddr_i=0x0000_1234 → mem_addr_o=0x0000_1230; mem_ready_i on cycle 3 keeps ADDR outputs stable through it; 4 rvalid beats → 4 irvalid_o pulses carrying matching data, then idone_o for exactly 1 cycle.
REQ-040 Simultaneous requests from reset: dgrant_o first; a second simultaneous contention grants instruction; a third grants data.
REQ-041 Write-back: dwe_i=1, daddr_i=0x80; mem_wready_i toggling 1,0,1,1,0,1 → mem_wdata_o follows beat_o 0..3, ddone_o one cycle after the 4th accepted beat, mem_we_o=1 throughout ADDR.
REQ-042 Late deassert: ireq_i dropped the cycle after grant → burst still completes with idone_o; spurious mem_rvalid_i injected in IDLE produces no irvalid_o/drvalid_o.
REQ-043 Reset mid-burst: rst_n low after 2 read beats → all outputs 0 in the same cycle with no clock edge, no done pulse; after release a new ireq_i yields a full 4-beat burst.
REQ-044 LINE_WORDS=8 build: iaddr_i=0x3F → mem_addr_o=0x20 and exactly 8 beats before idone_o.
